// File: rtl/add_sub_serial_p_if.sv
// add_sub_serial_p_if: start/mode/operand request and result/status bundle for add_sub_serial_p
interface add_sub_serial_p_if #(parameter int WIDTH = 8);
   logic en, sub, ready, done, cout, ovf;
   logic [WIDTH-1:0] a, b, out;
   modport master (output en, sub, a, b, input ready, done, out, cout, ovf);
   modport slave (input en, sub, a, b, output ready, done, out, cout, ovf);
endinterface

// File: rtl/add_sub_serial_p.sv
// add_sub_serial_p: digit-serial adder/subtractor, DIGIT bits per clock, with carry/overflow flags and ready/done handshake
module add_sub_serial_p #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic clk,
   input logic rst,
   add_sub_serial_p_if.slave bus
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
      $error("add_sub_serial_p: WIDTH must be >= 2 and a multiple of DIGIT");
   end
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg, out_r, out_nxt;
   logic [CW-1:0] count;
   logic [DIGIT:0] d;
   logic carry, cout_r, ovf_r, a_msb, b_msb, start, last;
   assign d = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
   assign start = bus.en && state != ADD;
   assign last = state == ADD && count == CW'(N - 1);
   if (DIGIT == WIDTH) begin : g_one
      assign out_nxt = d[DIGIT-1:0];
   end else begin : g_shift
      assign out_nxt = {d[DIGIT-1:0], out_r[WIDTH-1:DIGIT]};
   end
   assign bus.ready = state != ADD;
   assign bus.done = state == DONE;
   assign bus.out = out_r;
   assign bus.cout = cout_r;
   assign bus.ovf = ovf_r;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nxt;
   // a new request wins in IDLE/DONE; the last digit retires ADD into DONE
   always_comb
      state_nxt = start ? ADD : last ? DONE : state;
   // capture operands on start, then consume one digit per ADD cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         out_r <= '0;
         count <= '0;
         carry <= 1'b0;
         cout_r <= 1'b0;
         ovf_r <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (start) begin
         a_reg <= bus.a;
         b_reg <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub;
         out_r <= '0;
         count <= '0;
         cout_r <= 1'b0;
         ovf_r <= 1'b0;
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1] ^ bus.sub;
      end else if (state == ADD) begin
         out_r <= out_nxt;
         a_reg <= a_reg >> DIGIT;
         b_reg <= b_reg >> DIGIT;
         carry <= d[DIGIT];
         count <= count + 1'b1;
         if (last) begin
            cout_r <= d[DIGIT];
            ovf_r <= (a_msb == b_msb) && (d[DIGIT-1] != a_msb);
         end
      end
   end
endmodule
